// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory command port between an instruction-fetch
// requester (if_*) and a data requester (dm_*). Exactly one transaction is
// outstanding on the memory port at any time.
//
// Ports
//   clk, reset                 clock (rising edge) / async active-high reset
//   if_req, if_addr, if_kill   fetch request, word address, pipeline flush
//   if_done, if_rdata, if_err  fetch response pulse, data, bus error
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_be            data request (1=store), address, data, enables
//   dm_done, dm_rdata, dm_err  data response pulse, load data, bus error
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be          registered memory command
//   mem_ack, mem_rdata         memory completion pulse and read data
//   dbg_state                  current FSM state (IDLE/IF_BUSY/DM_BUSY/IF_DROP)
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until the matching *_done pulse. A request still high in the done cycle is
// taken as the next request, so the requester drops *_req in that cycle if it
// has nothing more to issue. On the memory side mem_req and the command stay
// stable until the cycle mem_ack is seen; mem_req is low the following cycle.
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_done,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_be,
  output logic            dm_done,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_DM_BUSY = 2'd2;
  localparam logic [1:0] ST_IF_DROP = 2'd3;

  // Last wait count before a timeout fires: TIMEOUT busy cycles without ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      wait_q, wait_d;
  logic [1:0]      dm_run_q, dm_run_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic            if_done_q, if_done_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic            if_err_q, if_err_d;
  logic            dm_done_q, dm_done_d;
  logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
  logic            dm_err_q, dm_err_d;

  logic grant_if, grant_dm, timeout_hit;

  // Data normally wins; after two data grants in a row while fetch was
  // waiting, fetch takes the next slot. A killed fetch is not eligible.
  assign grant_if = (state_q == ST_IDLE) && if_req && !if_kill &&
                    (!dm_req || (dm_run_q == 2'd2));
  assign grant_dm = (state_q == ST_IDLE) && dm_req && !grant_if;

  assign timeout_hit = (state_q != ST_IDLE) && !mem_ack && (wait_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    dm_run_d    = dm_run_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    // Response outputs are single-cycle and read as zero outside done.
    if_done_d   = 1'b0;
    if_rdata_d  = '0;
    if_err_d    = 1'b0;
    dm_done_d   = 1'b0;
    dm_rdata_d  = '0;
    dm_err_d    = 1'b0;

    if (!if_req) dm_run_d = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          state_d     = ST_IF_BUSY;
          wait_d      = 8'd0;
          dm_run_d    = 2'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
        end else if (grant_dm) begin
          state_d     = ST_DM_BUSY;
          wait_d      = 8'd0;
          if (if_req) dm_run_d = (dm_run_q == 2'd2) ? 2'd2 : dm_run_q + 2'd1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
        end
      end
      ST_IF_BUSY: begin
        if (mem_ack || timeout_hit) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          // A flush in the completion cycle discards the response.
          if (!if_kill) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
            if_err_d   = !mem_ack;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (if_kill) state_d = ST_IF_DROP;
        end
      end
      ST_DM_BUSY: begin
        if (mem_ack || timeout_hit) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          dm_done_d  = 1'b1;
          dm_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          dm_err_d   = !mem_ack;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_IF_DROP: begin
        // Let the killed fetch finish on the bus, then return silently.
        if (mem_ack || timeout_hit) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 8'd0;
      dm_run_q    <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'h0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      dm_done_q   <= 1'b0;
      dm_rdata_q  <= '0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      dm_run_q    <= dm_run_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      dm_done_q   <= dm_done_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter TIMEOUT, default 255, max cycles awaiting mem_ack before bus error; range 1..255.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  fetch request, held until if_done.
REQ-006 if_addr  in  XLEN  fetch word address.
REQ-007 if_kill  in  1  pipeline flush; discard in-flight fetch result.
REQ-008 if_done  out  1  fetch response pulse.
REQ-009 if_rdata  out  XLEN  fetch data, valid with if_done.
REQ-010 if_err  out  1  fetch bus error, valid with if_done.
REQ-011 dm_req  in  1  data request, held until dm_done.
REQ-012 dm_we  in  1  1=store, 0=load.
REQ-013 dm_addr / dm_wdata  in  XLEN each  data address / store data.
REQ-014 dm_be  in  4  store byte enables.
REQ-015 dm_done  out  1  data response pulse.
REQ-016 dm_rdata  out  XLEN  load data, valid with dm_done.
REQ-017 dm_err  out  1  data bus error, valid with dm_done.
REQ-018 mem_req, mem_we, mem_addr, mem_wdata, mem_be  out  1/1/XLEN/XLEN/4  shared memory port command, registered.
REQ-019 mem_ack  in  1  memory completion pulse; mem_rdata  in  XLEN  valid with mem_ack.

Function
REQ-020 FSM states IDLE, IF_BUSY, DM_BUSY, IF_DROP; exactly one transaction outstanding on mem port.
REQ-021 IDLE: grant chosen combinationally from requests sampled that cycle; selected command registered onto mem_* next cycle with mem_req=1; state -> IF_BUSY or DM_BUSY.
REQ-022 Priority: dm over if, except when dm granted 2 consecutive times while if_req was asserted, then if wins next arbitration; consecutive-dm counter clears on any if grant or when if_req low.
REQ-023 mem_req and mem_* command held stable until mem_ack; mem_req deasserts the cycle after mem_ack.
REQ-024 On mem_ack in IF_BUSY: if_done=1 one cycle later, if_rdata=mem_rdata, if_err=0; state -> IDLE.
REQ-025 On mem_ack in DM_BUSY: dm_done=1 one cycle later, dm_rdata=mem_rdata (0 for stores), dm_err=0; state -> IDLE.
REQ-026 Minimum request-to-done latency 3 cycles (grant, mem_req, ack same cycle -> done next); back-to-back grant allowed the cycle done asserts.
REQ-027 if_kill in IF_BUSY: state -> IF_DROP; transaction still completes on mem port; no if_done issued; IF_DROP -> IDLE on mem_ack.
REQ-028 if_kill in IDLE same cycle as if_req: fetch not granted that cycle; dm may be granted.
REQ-029 if_kill and mem_ack same cycle in IF_BUSY: response dropped, state -> IDLE.
REQ-030 8-bit wait counter clears at grant, increments each busy cycle without mem_ack; reaching TIMEOUT: mem_req deasserts, owner receives done with err=1, rdata=0, state -> IDLE; IF_DROP timeout returns to IDLE silently.
REQ-031 mem_ack in IDLE ignored; mem_ack in the cycle after timeout ignored.
REQ-032 if_done and dm_done never both asserted in one cycle.

Reset
REQ-033 reset asserted: state=IDLE, all outputs 0, counters 0, immediately and independent of clk.
REQ-034 reset mid-transaction: transaction abandoned, no done issued; first grant no earlier than first rising edge after deassertion.

Verification
REQ-035 Fetch only: if_req, if_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0x00000013 -> if_done with if_rdata=0x00000013, if_err=0.
REQ-036 Simultaneous if_req and dm_req store (addr 0x2000, be=0xF) held continuously -> grant order dm, dm, if, dm, dm, if.
REQ-037 if_kill one cycle after fetch grant -> no if_done, mem port completes, next dm_req granted after ack.
REQ-038 TIMEOUT=4, mem_ack never asserted on dm load -> dm_done with dm_err=1, dm_rdata=0 at 4 busy cycles; late mem_ack ignored.
REQ-039 reset pulsed while DM_BUSY -> all outputs 0 asynchronously, no dm_done afterward, fresh dm_req served normally.
